fb_port_arbiter: RTL and testbench
==================================

# fb_port_arbiter

Arbiter and sequencer for the single-port frame-buffer RAM shared between the UART-fed frame writer and the VGA pixel fetch. VGA reads always win, because they are real-time. UART pixel writes are buffered in a small FIFO and retired in cycles with no read. A clear engine fills the whole buffer with one colour, for example at power-up or on a host command. The block sits between the frame control logic, the VGA timing module and the RAM; everything runs in the `sclk` domain.

## Interface

Parameters:
- ADDR_W, 15, frame-buffer address width
- DATA_W, 8, pixel width (RGB 3-3-2)
- FB_WORDS, 19200, number of pixels cleared (160x120)
- FIFO_DEPTH, 4, write FIFO entries; must be a power of two, ≥2

Ports (one clock; reset is asynchronous and active-high):
- sclk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- rd_req  in  1  VGA fetch strobe, one pixel per pulse
- rd_addr  in  ADDR_W  fetch address, sampled with rd_req
- rd_valid  out  1  rd_data valid, one-cycle pulse per rd_req
- rd_data  out  DATA_W  fetched pixel
- wr_valid  in  1  pixel write offered
- wr_ready  out  1  write accepted when wr_valid & wr_ready at sclk edge
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write pixel
- clr_start  in  1  single-cycle clear request
- clr_data  in  DATA_W  fill colour, sampled with clr_start
- clr_busy  out  1  clear in progress
- ram_en  out  1  RAM access this cycle
- ram_we  out  1  RAM write (qualified by ram_en)
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after a read

## Operation

- The RAM port is driven combinationally each cycle, using this fixed priority:
  - rd_req: read at rd_addr.
  - Else, if CLEAR: write clr_colour at clr_addr.
  - Else, if FIFO not empty: write the FIFO head and pop it.
  - Else: ram_en=0.
- State machine, IDLE/CLEAR:
  - IDLE→CLEAR on clr_start. On entry: clr_addr=0, clr_colour=clr_data, FIFO flushed (pending entries discarded).
  - In CLEAR, clr_addr increments only in cycles where the clear write is granted.
  - CLEAR→IDLE after the write at FB_WORDS-1.
  - clr_start in CLEAR is ignored.
- clr_busy=1 exactly while in CLEAR.
- wr_ready = !fifo_full & !clr_busy. Writes are stalled during a clear, never dropped.
- FIFO is first-word-fall-through and holds {addr,data}. Push and pop in the same cycle are legal, including when the FIFO is full.
- Write ordering: FIFO writes retire in acceptance order. A read-after-write to the same address sees old data until that write retires; this is not checked.
- While rst=1: ram_en=0, ram_we=0.

## Timing

- Reset values:
  - rd_valid=0, rd_data=0, clr_busy=0
  - wr_ready=1, FIFO empty, state IDLE
  - ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0
- Read latency: rd_req in cycle N → ram_en in N → ram_rdata in N+1 → rd_valid/rd_data registered, visible in N+2.
- Back-to-back rd_req every cycle gives rd_valid every cycle and fully starves writes and the clear.
- Write: handshake at edge N → earliest RAM write in N+1, if no read.
- FIFO full: wr_ready=0 in the same cycle.
- Pop with simultaneous push while full: wr_ready stays 0 that cycle, because it is based on registered full. It rises in the next cycle.
- Clear: clr_start at edge N → clr_busy=1 from N+1, with the first clear write in N+1. With no reads, the clear takes exactly FB_WORDS cycles and clr_busy falls in cycle N+1+FB_WORDS.
- Clear and an accepted write in the same edge: the clear wins and the write is flushed.
- Reset mid-clear or with the FIFO holding data: return to IDLE, FIFO empty, no RAM access while rst=1.

## Structure

- Package fb_arb_pkg holds:
  - state enum {ST_IDLE, ST_CLEAR}
  - default ADDR_W/DATA_W/FB_WORDS/FIFO_DEPTH constants
  - the RGB332 colour constants used for clear colours
- One sub-module: fb_wr_fifo.
  - Parameterised first-word-fall-through FIFO for {ADDR_W+DATA_W} with a flush input.
  - Outputs: full and empty.
- The arbiter itself is combinational priority logic plus the clear counter and FSM.

## Test plan

- Reset release, idle inputs → all outputs at their reset values; ram_en=0 for 10 cycles.
- rd_req with rd_addr=0x0010 and RAM preloaded 0xE3 → rd_valid=1, rd_data=0xE3 exactly 2 cycles later; back-to-back reads stream one per cycle.
- Five writes offered while rd_req is held high → 4 accepted, wr_ready=0 on the fifth. Drop rd_req → four RAM writes in acceptance order on consecutive cycles, then wr_ready=1.
- clr_start with clr_data=0x1C and no reads → clr_busy high for exactly 19200 cycles; addresses 0..19199 written with 0x1C; wr_ready=0 throughout.
- clr_start with 3 writes pending and rd_req on alternate cycles → pending writes never reach RAM; clear completes in ~38400 cycles; rd_valid timing is unchanged.
- rst asserted at clear address 5000 → ram_en=0 immediately, clr_busy=0, FIFO empty; a new clr_start restarts at address 0.

Source files
------------

// File: rtl/fb_arb_pkg.sv
// Shared types and defaults for the frame-buffer port arbiter.
// Colour constants are RGB 3-3-2 (RRRGGGBB).
package fb_arb_pkg;

  localparam int ADDR_W_DEF     = 15;
  localparam int DATA_W_DEF     = 8;
  localparam int FB_WORDS_DEF   = 19200;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic [7:0] RGB_BLACK   = 8'h00;
  localparam logic [7:0] RGB_WHITE   = 8'hFF;
  localparam logic [7:0] RGB_RED     = 8'hE0;
  localparam logic [7:0] RGB_GREEN   = 8'h1C;
  localparam logic [7:0] RGB_BLUE    = 8'h03;
  localparam logic [7:0] RGB_MAGENTA = 8'hE3;

endpackage

// File: rtl/fb_wr_fifo.sv
// First-word-fall-through FIFO for buffered pixel writes, with a synchronous flush.
// A push while full is accepted only when a pop retires an entry in the same cycle.
module fb_wr_fifo #(
  parameter int WIDTH = 23,
  parameter int DEPTH = 4
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & !empty;
  assign do_push = push & (!full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  always_ff @(posedge sclk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: VGA reads first, then the clear engine,
// then buffered UART pixel writes.
module fb_port_arbiter
  import fb_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FB_WORDS   = FB_WORDS_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_data,
  output logic              clr_busy,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_t                     state;
  logic [ADDR_W-1:0]          clr_addr;
  logic [DATA_W-1:0]          clr_colour;
  logic                       rd_pend;
  logic                       clr_grant;
  logic                       clr_last;
  logic                       fifo_push;
  logic                       fifo_pop;
  logic                       fifo_flush;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [ADDR_W+DATA_W-1:0]   fifo_dout;

  assign clr_busy   = (state == ST_CLEAR);
  // wr_ready uses the registered full flag, so a pop does not reopen it in the same cycle
  assign wr_ready   = !fifo_full & !clr_busy;
  assign fifo_push  = wr_valid & wr_ready;
  assign fifo_flush = (state == ST_IDLE) & clr_start;
  assign clr_grant  = !rd_req & clr_busy;
  assign fifo_pop   = !rd_req & !clr_busy & !fifo_empty;
  assign clr_last   = (clr_addr == ADDR_W'(FB_WORDS - 1));

  fb_wr_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .sclk  (sclk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   ({wr_addr, wr_data}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (!rst) begin
      if (rd_req) begin
        ram_en   = 1'b1;
        ram_addr = rd_addr;
      end else if (clr_grant) begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = clr_addr;
        ram_wdata = clr_colour;
      end else if (!fifo_empty) begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = fifo_dout[ADDR_W+DATA_W-1:DATA_W];
        ram_wdata = fifo_dout[DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      clr_addr   <= '0;
      clr_colour <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clr_start) begin
            state      <= ST_CLEAR;
            clr_addr   <= '0;
            clr_colour <= clr_data;
          end
        end
        ST_CLEAR: begin
          if (clr_grant) begin
            if (clr_last) state <= ST_IDLE;
            else          clr_addr <= clr_addr + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // RAM returns data the cycle after the read; register it once more for the VGA side
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      rd_pend  <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_pend  <= rd_req;
      rd_valid <= rd_pend;
      if (rd_pend) rd_data <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Scoreboard bench for fb_port_arbiter: a queue-based model predicts every RAM
// access and read return; a negedge monitor pops and compares them.
module tb_fb_port_arbiter;

  localparam int ADDR_W     = 15;
  localparam int DATA_W     = 8;
  localparam int FB_WORDS   = 19200;
  localparam int FIFO_DEPTH = 4;

  typedef struct {
    logic        we;
    logic [14:0] addr;
    logic [7:0]  data;
    int          cyc;
  } op_t;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } rd_t;

  logic              sclk = 1'b0;
  logic              rst = 1'b1;
  logic              rd_req = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              clr_start = 1'b0;
  logic [DATA_W-1:0] clr_data = '0;
  logic              clr_busy;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata = '0;

  fb_port_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .FB_WORDS   (FB_WORDS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .sclk      (sclk),
    .rst       (rst),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .clr_start (clr_start),
    .clr_data  (clr_data),
    .clr_busy  (clr_busy),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 sclk = ~sclk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [7:0] ram     [0:32767];
  logic [7:0] mem_ref [0:32767];

  op_t pend[$];
  op_t exp_op[$];
  rd_t exp_rd[$];
  bit  m_clear = 1'b0;
  int  m_clr_addr = 0;
  logic [7:0] m_clr_colour = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  always @(posedge sclk) cyc <= cyc + 1;

  // Behavioural single-port RAM with one-cycle read latency
  always @(posedge sclk) begin
    if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram[ram_addr];
    end
  end

  always @(negedge sclk) begin
    op_t o;
    rd_t r;
    if (rst) begin
      chk("ram_en_in_reset", {31'd0, ram_en}, 32'd0);
    end else begin
      while (exp_op.size() > 0 && exp_op[0].cyc < cyc) begin
        o = exp_op.pop_front();
        chk("missing_ram_op_cycle", 32'(cyc), 32'(o.cyc));
      end
      if (ram_en) begin
        if (exp_op.size() == 0 || exp_op[0].cyc != cyc) begin
          chk("unexpected_ram_op", {31'd0, ram_en}, 32'd0);
        end else begin
          o = exp_op.pop_front();
          chk("ram_we", {31'd0, ram_we}, {31'd0, o.we});
          chk("ram_addr", 32'(ram_addr), 32'(o.addr));
          if (o.we) chk("ram_wdata", 32'(ram_wdata), 32'(o.data));
        end
      end
      while (exp_rd.size() > 0 && exp_rd[0].cyc < cyc) begin
        r = exp_rd.pop_front();
        chk("missing_rd_valid_cycle", 32'(cyc), 32'(r.cyc));
      end
      if (rd_valid) begin
        if (exp_rd.size() == 0 || exp_rd[0].cyc != cyc) begin
          chk("unexpected_rd_valid", {31'd0, rd_valid}, 32'd0);
        end else begin
          r = exp_rd.pop_front();
          chk("rd_data", 32'(rd_data), 32'(r.data));
        end
      end
    end
  end

  // Called at posedge+1 with this cycle's inputs applied; predicts the cycle, then advances.
  task automatic step();
    bit  rdy_e;
    bit  was_clear;
    op_t o;
    rdy_e = (pend.size() < FIFO_DEPTH) && !m_clear;
    chk("wr_ready", {31'd0, wr_ready}, {31'd0, rdy_e});
    chk("clr_busy", {31'd0, clr_busy}, {31'd0, m_clear});
    was_clear = m_clear;
    if (rd_req) begin
      exp_op.push_back('{1'b0, rd_addr, 8'h00, cyc});
      exp_rd.push_back('{mem_ref[rd_addr], cyc + 2});
    end else if (m_clear) begin
      exp_op.push_back('{1'b1, 15'(m_clr_addr), m_clr_colour, cyc});
      mem_ref[m_clr_addr] = m_clr_colour;
      if (m_clr_addr == FB_WORDS - 1) m_clear = 1'b0;
      else                            m_clr_addr++;
    end else if (pend.size() > 0) begin
      o = pend.pop_front();
      o.cyc = cyc;
      exp_op.push_back(o);
      mem_ref[o.addr] = o.data;
    end
    if (wr_valid && rdy_e) pend.push_back('{1'b1, wr_addr, wr_data, 0});
    if (clr_start && !was_clear) begin
      m_clear      = 1'b1;
      m_clr_addr   = 0;
      m_clr_colour = clr_data;
      pend.delete();
    end
    @(posedge sclk);
    #1;
  endtask

  task automatic idle_in();
    rd_req    = 1'b0;
    wr_valid  = 1'b0;
    clr_start = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, cycle %0d, expected end before 200000", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    int busy_cnt;
    int guard;
    for (int i = 0; i < 32768; i++) begin
      ram[i]     = 8'(i * 7 + 3);
      mem_ref[i] = 8'(i * 7 + 3);
    end
    ram[16'h0010]     = 8'hE3;
    mem_ref[16'h0010] = 8'hE3;

    #1;
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_clr_busy", {31'd0, clr_busy}, 32'd0);
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    repeat (2) @(posedge sclk);
    #1;
    rst = 1'b0;

    idle_in();
    repeat (10) step();

    // single read of the preloaded pixel, then a back-to-back stream
    rd_req  = 1'b1;
    rd_addr = 15'h0010;
    c0 = cyc;
    step();
    rd_req = 1'b0;
    step();
    chk("rd_latency_cycle", 32'(cyc), 32'(c0 + 2));
    chk("rd_valid_at_n2", {31'd0, rd_valid}, 32'd1);
    chk("rd_data_at_n2", 32'(rd_data), 32'hE3);
    step();
    for (int i = 0; i < 8; i++) begin
      rd_req  = 1'b1;
      rd_addr = 15'(16'h0100 + i);
      step();
    end
    idle_in();
    repeat (3) step();

    // five writes offered under continuous reads: four fit, the fifth stalls
    rd_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rd_addr  = 15'($urandom_range(0, 32767));
      wr_valid = 1'b1;
      wr_addr  = 15'(16'h2000 + i);
      wr_data  = 8'(8'h40 + i);
      if (i == 4) chk("fifth_wr_ready", {31'd0, wr_ready}, 32'd0);
      step();
    end
    idle_in();
    repeat (6) step();
    chk("wr_ready_after_drain", {31'd0, wr_ready}, 32'd1);

    // full clear, no reads, writes offered throughout
    clr_start = 1'b1;
    clr_data  = 8'h1C;
    step();
    clr_start = 1'b0;
    busy_cnt  = 0;
    for (int i = 0; i < FB_WORDS + 8; i++) begin
      wr_valid = (i < FB_WORDS - 4);
      wr_addr  = 15'($urandom_range(0, 32767));
      wr_data  = 8'($urandom);
      if (clr_busy) busy_cnt++;
      step();
    end
    chk("clear_busy_cycles", 32'(busy_cnt), 32'(FB_WORDS));
    idle_in();
    repeat (4) step();

    // reset in the middle of a clear
    clr_start = 1'b1;
    clr_data  = 8'hE0;
    step();
    clr_start = 1'b0;
    guard = 0;
    while (m_clear && m_clr_addr != 5000 && guard < 6000) begin
      step();
      guard++;
    end
    chk("clear_reached_5000", 32'(m_clr_addr), 32'd5000);
    rst = 1'b1;
    #1;
    chk("mid_clr_rst_ram_en", {31'd0, ram_en}, 32'd0);
    chk("mid_clr_rst_clr_busy", {31'd0, clr_busy}, 32'd0);
    chk("mid_clr_rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    m_clear = 1'b0;
    pend.delete();
    repeat (3) @(posedge sclk);
    #1;
    rst = 1'b0;
    step();

    // three writes parked behind reads, then a clear discards them; reads alternate
    rd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd_addr  = 15'($urandom_range(0, 32767));
      wr_valid = 1'b1;
      wr_addr  = 15'(16'h3000 + i);
      wr_data  = 8'(8'hA0 + i);
      step();
    end
    wr_valid  = 1'b0;
    rd_addr   = 15'($urandom_range(0, 32767));
    clr_start = 1'b1;
    clr_data  = 8'h03;
    step();
    clr_start = 1'b0;
    guard = 0;
    busy_cnt = 0;
    while (m_clear && guard < 2 * FB_WORDS + 100) begin
      rd_req  = guard[0];
      rd_addr = 15'($urandom_range(0, 32767));
      if (clr_busy) busy_cnt++;
      step();
      guard++;
    end
    chk("alt_read_clear_done", {31'd0, m_clear}, 32'd0);
    chk("alt_read_clear_len_ok", 32'((busy_cnt >= 2 * FB_WORDS - 2) && (busy_cnt <= 2 * FB_WORDS + 1)), 32'd1);
    idle_in();
    repeat (4) step();

    // randomized mix of reads and writes
    for (int i = 0; i < 2000; i++) begin
      rd_req   = ($urandom_range(0, 9) < 4);
      rd_addr  = 15'($urandom_range(0, 32767));
      wr_valid = ($urandom_range(0, 9) < 6);
      wr_addr  = 15'($urandom_range(0, 32767));
      wr_data  = 8'($urandom);
      step();
    end
    idle_in();
    repeat (8) step();

    chk("ram_ops_outstanding", 32'(exp_op.size()), 32'd0);
    chk("reads_outstanding", 32'(exp_rd.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
